// File: rtl/bit_sync_filt_pkg.sv
// Shared system defaults for the bit synchronizer and helpers used by its channel logic.
package bit_sync_filt_pkg;

    localparam int unsigned DEF_NUM_STAGES = 32'd2;
    localparam int unsigned DEF_BUS_WIDTH  = 32'd4;
    localparam int unsigned DEF_FILT_LEN   = 32'd4;

    // Counter must be able to hold FILT_LEN-1; sized on FILT_LEN+1 so FILT_LEN=1 still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned filt_len);
        return $clog2(filt_len + 32'd1);
    endfunction

endpackage

// File: rtl/bit_sync_filt_chan.sv
// One synchronized channel: flop chain, stability filter and registered edge pulses.
module bit_sync_filt_chan
    import bit_sync_filt_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned FILT_LEN   = DEF_FILT_LEN
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    input  logic filt_en,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic chg_nxt
);

    localparam int unsigned CW = cnt_width(FILT_LEN);

    logic [NUM_STAGES-1:0] chain_r;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_nxt_s;
    logic                  s_out_s;
    logic                  sync_r;
    logic                  sync_nxt_s;
    logic                  rise_nxt_s;
    logic                  fall_nxt_s;
    logic                  rise_r;
    logic                  fall_r;

    assign s_out_s = chain_r[NUM_STAGES-1];

    // Metastability chain: stage 0 samples the asynchronous input.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chain_r <= {NUM_STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[NUM_STAGES-2:0], async_in};
        end
    end

    // Filter decision: a new level is accepted only after it has differed from SYNC for FILT_LEN edges.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        sync_nxt_s = sync_r;
        if (!filt_en) begin
            cnt_nxt_s  = {CW{1'b0}};
            sync_nxt_s = s_out_s;
        end else if (s_out_s == sync_r) begin
            cnt_nxt_s  = {CW{1'b0}};
        end else if (cnt_r == CW'(FILT_LEN - 32'd1)) begin
            cnt_nxt_s  = {CW{1'b0}};
            sync_nxt_s = s_out_s;
        end else begin
            cnt_nxt_s  = cnt_r + CW'(32'd1);
        end
    end

    // Edges are taken from the next-state value so pulses land in the same cycle SYNC changes.
    always_comb begin
        rise_nxt_s = sync_nxt_s & ~sync_r;
        fall_nxt_s = ~sync_nxt_s & sync_r;
    end

    // Filter counter, synchronized level and edge pulse registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r  <= {CW{1'b0}};
            sync_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            sync_r <= sync_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
        end
    end

    assign sync_out   = sync_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign chg_nxt    = rise_nxt_s | fall_nxt_s;

endmodule

// File: rtl/bit_sync_filt.sv
// Multi-channel synchronizer with optional glitch filter and per-channel rise/fall pulses.
module bit_sync_filt
    import bit_sync_filt_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int unsigned FILT_LEN   = DEF_FILT_LEN
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNCH,
    input  logic                 FILT_EN,
    output logic [BUS_WIDTH-1:0] SYNC,
    output logic [BUS_WIDTH-1:0] RISE_PULSE,
    output logic [BUS_WIDTH-1:0] FALL_PULSE,
    output logic                 ANY_CHG
);

    if (NUM_STAGES < 32'd2) begin : g_bad_stages
        $error("bit_sync_filt: NUM_STAGES must be >= 2");
    end
    if (BUS_WIDTH < 32'd1) begin : g_bad_width
        $error("bit_sync_filt: BUS_WIDTH must be >= 1");
    end
    if (FILT_LEN < 32'd1) begin : g_bad_filt
        $error("bit_sync_filt: FILT_LEN must be >= 1");
    end

    logic [BUS_WIDTH-1:0] chg_nxt_s;
    logic                 any_chg_r;

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
        bit_sync_filt_chan #(
            .NUM_STAGES (NUM_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_chan (
            .CLK        (CLK),
            .RST        (RST),
            .async_in   (ASYNCH[i]),
            .filt_en    (FILT_EN),
            .sync_out   (SYNC[i]),
            .rise_pulse (RISE_PULSE[i]),
            .fall_pulse (FALL_PULSE[i]),
            .chg_nxt    (chg_nxt_s[i])
        );
    end

    // Registered OR of the per-channel next-cycle pulses keeps ANY_CHG aligned with the pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            any_chg_r <= 1'b0;
        end else begin
            any_chg_r <= |chg_nxt_s;
        end
    end

    assign ANY_CHG = any_chg_r;

endmodule
